// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-master bus arbiter.
package bus_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

  typedef logic mst_idx_t;
  localparam mst_idx_t MST_CPU = 1'b0;
  localparam mst_idx_t MST_DMA = 1'b1;

  // Round-robin pick: the sole requester, or whoever did not go last.
  function automatic mst_idx_t rr_pick(input logic req0, input logic req1, input mst_idx_t prev);
    if (req0 && req1) return ~prev;
    else if (req1)    return MST_DMA;
    else              return MST_CPU;
  endfunction

endpackage

// File: rtl/bus_arb_wdt.sv
// Transaction watchdog: counts BUSY cycles and flags the last allowed one.
module bus_wdt #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] cnt;

  assign expire = en && (cnt == CW'(TIMEOUT_CYC - 1));

  // Holds at the terminal value; the arbiter leaves BUSY on expire anyway.
  always_ff @(posedge clk) begin
    if (!rst_n)                cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (en && !expire)    cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/dffr.sv
// Enabled D flip-flop with synchronous active-low reset to a parameterised value.
module dffr #(
  parameter int            W       = 1,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n)  q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/bus_arb.sv
// Two-master round-robin bus arbiter with one outstanding transaction and a
// watchdog that completes unacknowledged transactions with an error response.
module bus_arb
  import bus_arb_pkg::*;
#(
  parameter int          TIMEOUT_CYC = 1024,
  parameter logic [31:0] ERR_RDATA   = ERR_RDATA_DEF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        m0_valid_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_wstrb_i,
  output logic [31:0] m0_rdata_o,
  output logic        m0_ready_o,
  input  logic        m1_valid_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_wstrb_i,
  output logic [31:0] m1_rdata_o,
  output logic        m1_ready_o,
  output logic        bus_valid_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_wstrb_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ready_i,
  output logic        err_o,
  output logic [31:0] err_addr_o,
  output logic        err_mst_o,
  output arb_state_e  dbg_state_o
);

  // Handshake: a master raises valid and holds it with stable address/data
  // until its ready pulses for one cycle; the bus side uses the same rule
  // with bus_valid_o / bus_ready_i, and ready is ignored while not BUSY.

  arb_state_e  state_q, state_d;
  mst_idx_t    owner_q, owner_d;
  mst_idx_t    last_q, last_d;
  logic        wdt_clr, wdt_en, wdt_expire;
  logic        done, timeout, busy;
  logic [31:0] sel_addr, sel_wdata, resp_rdata;
  logic [3:0]  sel_wstrb;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      owner_q <= MST_CPU;
      last_q  <= MST_DMA;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wdt_clr = 1'b0;
    wdt_en  = 1'b0;
    done    = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_valid_i || m1_valid_i) begin
          owner_d = rr_pick(m0_valid_i, m1_valid_i, last_q);
          wdt_clr = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        wdt_en = 1'b1;
        // A real acknowledge in the expiry cycle wins over the timeout.
        if (bus_ready_i) begin
          done = 1'b1;
        end else if (wdt_expire) begin
          done    = 1'b1;
          timeout = 1'b1;
        end
        if (done) begin
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  bus_wdt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdt (
    .clk    (clk_i),
    .rst_n  (rst_n_i),
    .clr    (wdt_clr),
    .en     (wdt_en),
    .expire (wdt_expire)
  );

  assign busy       = (state_q == BUSY);
  assign sel_addr   = (owner_q == MST_DMA) ? m1_addr_i  : m0_addr_i;
  assign sel_wdata  = (owner_q == MST_DMA) ? m1_wdata_i : m0_wdata_i;
  assign sel_wstrb  = (owner_q == MST_DMA) ? m1_wstrb_i : m0_wstrb_i;
  assign resp_rdata = timeout ? ERR_RDATA : bus_rdata_i;

  always_comb begin
    bus_valid_o = busy;
    bus_addr_o  = busy ? sel_addr  : '0;
    bus_wdata_o = busy ? sel_wdata : '0;
    bus_wstrb_o = busy ? sel_wstrb : '0;
    m0_ready_o  = busy && (owner_q == MST_CPU) && done;
    m1_ready_o  = busy && (owner_q == MST_DMA) && done;
    m0_rdata_o  = (busy && (owner_q == MST_CPU)) ? resp_rdata : '0;
    m1_rdata_o  = (busy && (owner_q == MST_DMA)) ? resp_rdata : '0;
    err_o       = timeout;
  end

  dffr #(.W(32)) u_err_addr (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .en    (timeout),
    .d     (sel_addr),
    .q     (err_addr_o)
  );

  dffr #(.W(1)) u_err_mst (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .en    (timeout),
    .d     (owner_q),
    .q     (err_mst_o)
  );

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bus_arb.sv
// Self-checking bench for bus_arb: directed scenarios plus randomized traffic
// against a transaction-schedule reference model and a response scoreboard.
module tb_bus_arb;
  import bus_arb_pkg::*;

  localparam int          T     = 8;
  localparam logic [31:0] ERR   = 32'hDEAD_BEEF;
  localparam int          NEVER = 1000;
  localparam int          BIG   = 32'h7fff_ffff;

  typedef struct {
    int          mst;
    logic [31:0] rdata;
    logic        err;
    int          end_cyc;
  } resp_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mv[2];
  logic [31:0] ma[2];
  logic [31:0] mw[2];
  logic [3:0]  ms[2];
  logic [31:0] m_rd[2];
  logic        m_rdy[2];
  logic        bus_valid, bus_ready, err, err_mst;
  logic [31:0] bus_addr, bus_wdata, bus_rdata, err_addr;
  logic [3:0]  bus_wstrb;
  arb_state_e  dbg_state;

  always #5 clk = ~clk;

  bus_arb #(.TIMEOUT_CYC(T)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .m0_valid_i  (mv[0]),
    .m0_addr_i   (ma[0]),
    .m0_wdata_i  (mw[0]),
    .m0_wstrb_i  (ms[0]),
    .m0_rdata_o  (m_rd[0]),
    .m0_ready_o  (m_rdy[0]),
    .m1_valid_i  (mv[1]),
    .m1_addr_i   (ma[1]),
    .m1_wdata_i  (mw[1]),
    .m1_wstrb_i  (ms[1]),
    .m1_rdata_o  (m_rd[1]),
    .m1_ready_o  (m_rdy[1]),
    .bus_valid_o (bus_valid),
    .bus_addr_o  (bus_addr),
    .bus_wdata_o (bus_wdata),
    .bus_wstrb_o (bus_wstrb),
    .bus_rdata_i (bus_rdata),
    .bus_ready_i (bus_ready),
    .err_o       (err),
    .err_addr_o  (err_addr),
    .err_mst_o   (err_mst),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard / reference model state ----------------
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  resp_t       exp_q[$];
  resp_t       e;
  int          next_decide = BIG;
  int          m_last = 1;
  bit          in_flight = 0;
  int          cur_start, cur_end, cur_own;
  bit          cur_err;
  logic [31:0] cur_rd, cur_addr;
  int          rdy_cyc = -1;
  int          spur_cyc = -1;
  logic [31:0] exp_err_addr = '0;
  logic        exp_err_mst = 1'b0;
  int          force_k[2];
  logic [31:0] force_rd[2];
  bit          force_spur[2];
  bit          busy, last_cyc;
  int          w, k, d;
  logic [31:0] rd;
  bit          sp;
  int          rsel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Slave: acknowledges in the BUSY cycle chosen by the model, optionally
  // repeats ready one cycle late like a registered-ready SRAM.
  initial begin
    bus_ready = 1'b0;
    bus_rdata = '0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      bus_ready = (cyc == rdy_cyc) || (cyc == spur_cyc);
      bus_rdata = (cyc == rdy_cyc) ? cur_rd : $urandom;
    end
  end

  // Monitor + model: check this cycle, then advance the transaction schedule.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      busy     = in_flight && (cyc >= cur_start) && (cyc <= cur_end);
      last_cyc = busy && (cyc == cur_end);

      chk("bus_valid", 32'(bus_valid), 32'(busy));
      chk("state", 32'(dbg_state), busy ? 32'(BUSY) : 32'(IDLE));
      if (busy) begin
        chk("bus_addr",  bus_addr, ma[cur_own]);
        chk("bus_wdata", bus_wdata, mw[cur_own]);
        chk("bus_wstrb", 32'(bus_wstrb), 32'(ms[cur_own]));
      end else if (!rst_n) begin
        chk("rst_bus_addr", bus_addr, 32'h0);
      end
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("m%0d_ready", m), 32'(m_rdy[m]), 32'(last_cyc && (cur_own == m)));
        chk($sformatf("m%0d_rdata", m), m_rd[m],
            (busy && (cur_own == m)) ? ((last_cyc && cur_err) ? ERR : bus_rdata) : 32'h0);
      end
      chk("err_o", 32'(err), 32'(last_cyc && cur_err));
      chk("err_addr", err_addr, exp_err_addr);
      chk("err_mst", 32'(err_mst), 32'(exp_err_mst));

      if (m_rdy[0] || m_rdy[1]) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL stray_ready at cycle %0d: ready m0=%0b m1=%0b with nothing outstanding",
                   cyc, m_rdy[0], m_rdy[1]);
        end else begin
          e = exp_q.pop_front();
          rsel = m_rdy[1] ? 1 : 0;
          chk("resp_mst", 32'(rsel), 32'(e.mst));
          chk("resp_rdata", m_rd[rsel], e.rdata);
          chk("resp_err", 32'(err), 32'(e.err));
          chk("resp_cycle", 32'(cyc), 32'(e.end_cyc));
        end
      end

      if (last_cyc) begin
        if (cur_err) begin
          exp_err_addr = cur_addr;
          exp_err_mst  = cur_own[0];
        end
        in_flight = 0;
      end

      if (!rst_n) begin
        in_flight    = 0;
        exp_q.delete();
        m_last       = 1;
        exp_err_addr = '0;
        exp_err_mst  = 1'b0;
        rdy_cyc      = -1;
        spur_cyc     = -1;
        next_decide  = BIG;
      end else begin
        if (next_decide == BIG) next_decide = cyc;
        if (!in_flight && (cyc >= next_decide) && (mv[0] || mv[1])) begin
          w = (mv[0] && mv[1]) ? (1 - m_last) : (mv[1] ? 1 : 0);
          if (force_k[w] >= 0) begin
            k  = force_k[w];
            rd = force_rd[w];
            sp = force_spur[w];
          end else begin
            case ($urandom_range(0, 9))
              6:       k = T;
              7:       k = T - 1;
              8, 9:    k = NEVER;
              default: k = $urandom_range(1, 3);
            endcase
            rd = $urandom;
            sp = ($urandom_range(0, 1) == 1);
          end
          cur_err     = (k > T);
          d           = cur_err ? T : k;
          cur_own     = w;
          cur_start   = cyc + 1;
          cur_end     = cyc + d;
          cur_addr    = ma[w];
          cur_rd      = rd;
          next_decide = cyc + d + 1;
          rdy_cyc     = cur_err ? -1 : cyc + k;
          spur_cyc    = (sp && !cur_err) ? cyc + k + 1 : -1;
          in_flight   = 1;
          m_last      = w;
          exp_q.push_back('{mst: w, rdata: cur_err ? ERR : rd, err: cur_err, end_cyc: cyc + d});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input int m, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input bit keep);
    int n;
    @(posedge clk);
    #1;
    mv[m] = 1'b1;
    ma[m] = a;
    mw[m] = wd;
    ms[m] = st;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_rdy[m] && (n < 400));
    if (!m_rdy[m]) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_ready_m%0d: no ready within 400 cycles (cycle %0d)", m, cyc);
    end
    if (!keep) begin
      @(posedge clk);
      #1;
      mv[m] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic rand_master(input int m, input int n);
    bit keep;
    for (int i = 0; i < n; i++) begin
      keep = (i < n - 1) && ($urandom_range(0, 1) == 1);
      issue(m, $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(0, 15)), keep);
      if (!keep) repeat ($urandom_range(0, 3)) @(posedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    for (int m = 0; m < 2; m++) begin
      mv[m] = 1'b0; ma[m] = '0; mw[m] = '0; ms[m] = '0;
      force_k[m] = -1; force_rd[m] = '0; force_spur[m] = 0;
    end

    // Both masters request through reset; m0 must win the first contention.
    fork
      issue(0, 32'h0100_0000, 32'h1111_0000, 4'hF, 0);
      issue(1, 32'h0200_0004, 32'h2222_0000, 4'h0, 0);
      begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
      end
    join
    idle(3);

    // Registered-ready slave: ack in BUSY cycle 2, spurious ready in the gap.
    force_k[0] = 2; force_rd[0] = 32'h1234_5678; force_spur[0] = 1;
    issue(0, 32'h0300_0010, 32'h0, 4'h0, 0);
    force_k[0] = -1;
    idle(3);

    // Sustained contention: grants must alternate.
    fork
      for (int i = 0; i < 3; i++) issue(0, 32'h1000_0000 + 32'(i * 4), $urandom, 4'hF, i < 2);
      for (int i = 0; i < 3; i++) issue(1, 32'h2000_0000 + 32'(i * 4), $urandom, 4'hF, i < 2);
    join
    idle(3);

    // Timeout on an m1 write while m0 waits.
    force_k[1] = NEVER;
    fork
      issue(1, 32'h0400_0000, 32'hCAFE_0001, 4'hF, 0);
      begin
        idle(3);
        issue(0, 32'h0400_0100, 32'h0, 4'h0, 0);
      end
    join
    force_k[1] = -1;
    idle(3);

    // Acknowledge lands exactly in the expiry cycle.
    force_k[0] = T; force_rd[0] = 32'hB0B0_0008; force_spur[0] = 0;
    issue(0, 32'h0400_0200, 32'h0000_0055, 4'h3, 0);
    force_k[0] = -1;
    idle(3);

    // Reset in BUSY cycle 3 of an m1 transaction that the slave never acks.
    force_k[1] = NEVER;
    @(posedge clk);
    #1;
    mv[1] = 1'b1; ma[1] = 32'h0500_0000; mw[1] = 32'h7777_7777; ms[1] = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    mv[1] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    force_k[1] = -1;
    idle(3);

    // Randomized two-master traffic.
    fork
      rand_master(0, 30);
      rand_master(1, 30);
    join
    idle(12);

    @(posedge clk);
    #2;
    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: bench did not complete by cycle %0d", cyc);
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/bus_arb.md
# bus_arb

Two-master round-robin arbiter with a transaction watchdog. It sits between the two requesters (m0 = CPU core, m1 = DMA engine) and the single core-side port of the address decoder. It grants one outstanding valid/ready transaction at a time and terminates any transaction that a slave never acknowledges.

## Interface

Parameters:
- `TIMEOUT_CYC`, default 1024: BUSY cycles allowed before forced termination. Legal range ≥ 2.
- `ERR_RDATA`, default 32'hDEAD_BEEF: read data returned on timeout.

Ports:
- `clk_i` in 1: single clock.
- `rst_n_i` in 1: reset, synchronous, active-low.
- `m0_valid_i` in 1: master 0 request. Held until `m0_ready_o`.
- `m0_addr_i` / `m0_wdata_i` in 32: master 0 address / write data.
- `m0_wstrb_i` in 4: master 0 byte strobes. 0 = read.
- `m0_rdata_o` out 32: master 0 read data.
- `m0_ready_o` out 1: master 0 completion, one-cycle pulse.
- `m1_*`: identical set for master 1.
- `bus_valid_o` out 1: request to the decoder.
- `bus_addr_o` / `bus_wdata_o` out 32: address / write data to the decoder.
- `bus_wstrb_o` out 4: byte strobes to the decoder.
- `bus_rdata_i` in 32: read data from the decoder.
- `bus_ready_i` in 1: completion from the decoder.
- `err_o` out 1: one-cycle pulse on timeout.
- `err_addr_o` out 32: address of the last timed-out transaction, held until the next timeout.
- `err_mst_o` out 1: master that owned the last timed-out transaction.

## Operation

- FSM states: IDLE, BUSY.
- Registers: `owner` (1 b), `last` (1 b), watchdog counter `cnt` (width $clog2(TIMEOUT_CYC)).
- **IDLE:**
  - `bus_valid_o` = 0. `bus_ready_i` is ignored.
  - If any `mX_valid_i` is high: `owner` ← winner, `cnt` ← 0, go to BUSY.
  - Winner: the sole requester, or `!last` if both request.
- **BUSY:**
  - `bus_valid_o` = 1.
  - `bus_addr_o`, `bus_wdata_o`, `bus_wstrb_o` = owner's live inputs, muxed combinationally.
  - `mX_ready_o` = `bus_ready_i` for the owner, 0 for the other master. `mX_rdata_o` = `bus_rdata_i` for the owner.
- **Normal completion:** `bus_ready_i` high in BUSY → owner's ready is pulsed in that cycle, `last` ← `owner`, go to IDLE.
- **Timeout:** in BUSY with `cnt` == TIMEOUT_CYC-1 and `bus_ready_i` low:
  - Owner's `mX_ready_o` = 1 and `mX_rdata_o` = ERR_RDATA for that cycle.
  - `err_o` = 1. `err_addr_o` ← `bus_addr_o`, `err_mst_o` ← `owner`.
  - `last` ← `owner`, go to IDLE.
  - `cnt` otherwise increments every BUSY cycle. It does not wrap: the timeout exits BUSY first.
- **`bus_ready_i` and the timeout condition in the same cycle:** normal completion wins; no error.
- **Mandatory IDLE gap:** exactly one IDLE cycle follows every transaction.
  - Slaves with registered ready (SRAM) re-assert ready one cycle after valid drops. The gap absorbs that spurious pulse.
  - The gap also gives strict alternation under contention.
- **Non-owner:** `mX_ready_o` = 0 and `mX_rdata_o` = 0. Its request waits.
- **Owner drops valid mid-transaction:** this is a protocol violation. The transaction continues until ready or timeout, and the response is delivered regardless.

## Timing

- Reset (synchronous, `rst_n_i` = 0 at a clock edge):
  - State = IDLE, `owner` = 0, `last` = 1 (m0 wins first contention), `cnt` = 0.
  - `err_addr_o` = 0, `err_mst_o` = 0.
  - All outputs 0.
- Reset mid-BUSY: the transaction is abandoned with no ready pulse. `bus_valid_o` = 0 in the cycle after the reset edge.
- Request accept latency: valid seen at edge t → `bus_valid_o` high in cycle t+1.
- Completion: `mX_ready_o` in the same cycle as `bus_ready_i` (combinational).
- Back-to-back throughput: one transaction per (slave latency + 2) cycles.
- Timeout: `mX_ready_o` / `err_o` in the TIMEOUT_CYC-th BUSY cycle.
- Starvation bound: a waiting master is granted within one transaction plus one IDLE cycle, or within TIMEOUT_CYC+1 cycles worst case.

## Structure

- Package `bus_arb_pkg` holds:
  - state enum `arb_state_e` {IDLE, BUSY};
  - `ERR_RDATA_DEF` default constant;
  - master index typedef.
- Sub-module `bus_wdt`:
  - inputs: `clr` (IDLE→BUSY), `en` (BUSY);
  - output: `expire`;
  - parameter TIMEOUT_CYC.
- Output registers use the existing `dffr`.

## Test plan

- **Reset:** hold `rst_n_i` low 3 cycles with both valids high → all outputs 0. First grant goes to m0; `bus_valid_o` rises one cycle after release.
- **Single master, registered-ready slave:** m0 read of 0x0300_0010 against a slave with 1-cycle ready returning 0x1234_5678 → `m0_rdata_o` = 0x1234_5678 with `m0_ready_o` in BUSY cycle 2. The spurious ready in the following IDLE cycle produces no extra pulse.
- **Contention:** m0 and m1 held valid continuously for 6 transactions → grants alternate m0, m1, m0, …. `bus_valid_o` low for exactly one cycle between transactions.
- **Timeout:** TIMEOUT_CYC = 8, m1 write to 0x0400_0000 with `bus_ready_i` never asserted → in BUSY cycle 8: `m1_ready_o` = 1, `m1_rdata_o` = 0xDEAD_BEEF, `err_o` pulses, `err_addr_o` = 0x0400_0000, `err_mst_o` = 1. The next grant goes to m0 if requesting.
- **Boundary:** `bus_ready_i` asserted exactly in the timeout cycle → normal completion with bus data; `err_o` stays 0.
- **Reset mid-BUSY:** assert reset in BUSY cycle 3 → no ready pulse. FSM is IDLE and `bus_valid_o` = 0 in the cycle after the reset edge.
